// File: rtl/sys_defs.sv
// Shared system definitions for the dispatch path.
// Provides the machine width, the branch-stack depth, the fetched and decoded
// instruction packet types, and the single-instruction decode helper.
package sys_defs;

  // Superscalar width shared by fetch, decode and dispatch.
  localparam int unsigned SUPERSCALAR_WAYS   = 4;
  // Branch-stack depth; also the most branches dispatch may issue per cycle.
  localparam int unsigned BRANCH_STACK_DEPTH = 2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } INST_PACKET;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  dest_reg;
    logic        cond_branch;
    logic        uncond_branch;
  } DECODED_PACKET;

  // Invalid input decodes to an all-zero packet so empty slots stay clean.
  function automatic DECODED_PACKET decode_inst(input INST_PACKET p);
    DECODED_PACKET d;
    logic [6:0]    op;
    d  = '0;
    op = p.inst[6:0];
    if (p.valid) begin
      d.valid         = 1'b1;
      d.pc            = p.pc;
      d.inst          = p.inst;
      d.cond_branch   = (op == OP_BRANCH);
      d.uncond_branch = (op == OP_JAL) || (op == OP_JALR);
      // Conditional branches and stores carry immediate bits in the rd field.
      d.dest_reg      = ((op == OP_BRANCH) || (op == OP_STORE)) ? 5'd0 : p.inst[11:7];
    end
    return d;
  endfunction

endpackage

// File: rtl/dispatch_buffer_decode.sv
// Decode stage in front of the dispatch buffer.
// Ports:
//   insts_i   - N fetched instruction packets
//   decoded_o - N decoded packets, same slot order; invalid slots are all-zero
module dispatch_buffer_decode
  import sys_defs::*;
#(
  parameter int unsigned N = SUPERSCALAR_WAYS
) (
  input  INST_PACKET    [N-1:0] insts_i,
  output DECODED_PACKET [N-1:0] decoded_o
);

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      decoded_o[i] = decode_inst(insts_i[i]);
    end
  end

endmodule

// File: rtl/dispatch_buffer.sv
// Dispatch buffer: circular queue of decoded instructions between fetch and
// the ROB/RS. Accepts up to N instructions per cycle and dispatches up to N in
// program order, limited by ROB/RS space, occupancy and branch-stack space.
// Ports:
//   clock, reset   - clock; synchronous active-high reset
//   insts          - fetched instructions, valid bits contiguous from slot 0
//   rob_open       - free ROB slots this cycle
//   rs_open        - free RS slots this cycle
//   bs_open        - free branch-stack entries this cycle
//   flush          - squash all buffered and incoming instructions
//   num_accept     - instructions fetch may present (from registered count)
//   num_dispatch   - instructions leaving the buffer this cycle
//   out_insts      - dispatched instructions, oldest in slot 0
//   count          - registered occupancy
module dispatch_buffer
  import sys_defs::*;
#(
  parameter int unsigned N      = SUPERSCALAR_WAYS,
  parameter int unsigned DEPTH  = 4 * SUPERSCALAR_WAYS,
  parameter int unsigned MAX_BR = BRANCH_STACK_DEPTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  INST_PACKET    [N-1:0]          insts,
  input  logic [$clog2(N+1)-1:0]         rob_open,
  input  logic [$clog2(N+1)-1:0]         rs_open,
  input  logic [$clog2(MAX_BR+1)-1:0]    bs_open,
  input  logic                           flush,
  output logic [$clog2(N+1)-1:0]         num_accept,
  output logic [$clog2(N+1)-1:0]         num_dispatch,
  output DECODED_PACKET [N-1:0]          out_insts,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned NW = $clog2(N + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  DECODED_PACKET [N-1:0] decoded;

  DECODED_PACKET mem_q [DEPTH];
  DECODED_PACKET mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  int   free_slots;
  int   accept_n;
  int   valid_n;
  logic valid_run;
  int   enq_n;
  int   limit_n;
  int   br_cap;
  int   br_n;
  int   disp_n;
  logic blocked;
  logic is_br;

  DECODED_PACKET head_ent;

  function automatic logic [PW-1:0] wrap_ptr(input logic [PW-1:0] base, input int off);
    return PW'((int'(base) + off) % int'(DEPTH));
  endfunction

  dispatch_buffer_decode #(
    .N (N)
  ) u_decode (
    .insts_i   (insts),
    .decoded_o (decoded)
  );

  // Accept and enqueue sizing. num_accept depends only on registered count so
  // fetch never sees a path from downstream back-pressure.
  always_comb begin
    free_slots = int'(DEPTH) - int'(count_q);
    accept_n   = (free_slots < int'(N)) ? free_slots : int'(N);

    valid_n   = 0;
    valid_run = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      if (valid_run && insts[i].valid) begin
        valid_n = valid_n + 1;
      end else begin
        valid_run = 1'b0;
      end
    end

    enq_n = (valid_n < accept_n) ? valid_n : accept_n;
    if (reset || flush) begin
      enq_n = 0;
    end
    num_accept = NW'(accept_n);
  end

  // Dispatch selection from head. Only entries present at the start of the
  // cycle are eligible, so same-cycle enqueues wait until the next cycle.
  always_comb begin
    limit_n = int'(rob_open);
    if (int'(rs_open) < limit_n) limit_n = int'(rs_open);
    if (int'(count_q) < limit_n) limit_n = int'(count_q);
    if (int'(N) < limit_n)       limit_n = int'(N);
    if (reset || flush)          limit_n = 0;

    br_cap   = (int'(bs_open) < int'(MAX_BR)) ? int'(bs_open) : int'(MAX_BR);
    br_n     = 0;
    disp_n   = 0;
    blocked  = 1'b0;
    is_br    = 1'b0;
    head_ent = '0;
    for (int i = 0; i < int'(N); i++) begin
      out_insts[i] = '0;
      head_ent     = mem_q[wrap_ptr(head_q, i)];
      is_br        = head_ent.cond_branch || head_ent.uncond_branch;
      if (!blocked && (i < limit_n)) begin
        if (is_br && (br_n >= br_cap)) begin
          blocked = 1'b1;
        end else begin
          out_insts[i] = head_ent;
          disp_n       = disp_n + 1;
          if (is_br) br_n = br_n + 1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
    num_dispatch = NW'(disp_n);
  end

  // Storage and pointer next state; head and tail move independently.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < int'(N); i++) begin
      if (i < enq_n) begin
        mem_d[wrap_ptr(tail_q, i)] = decoded[i];
      end
    end
    head_d  = wrap_ptr(head_q, disp_n);
    tail_d  = wrap_ptr(tail_q, enq_n);
    count_d = CW'(int'(count_q) + enq_n - disp_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        mem_q[j].valid <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign count = count_q;

endmodule
